// File: rtl/wiredng_cache_pkg.sv
// Shared types and constants for the cache bank miss-refill path.
package wiredng_cache_pkg;

    localparam int CACHE_PA_LENGTH = 48;
    localparam int LINE_BYTES      = 16;
    localparam int BEATS_PER_LINE  = 2;
    localparam int INDEX_LSB       = $clog2(LINE_BYTES);
    localparam int INDEX_MSB       = 13;
    localparam int TAG_LSB         = INDEX_MSB + 1;

    typedef struct packed {
        logic                             valid;
        logic [CACHE_PA_LENGTH-1:TAG_LSB] tag;
    } cache_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_TAG,
        ST_DONE
    } refill_state_t;

endpackage

// File: rtl/wiredng_cache_victim_sel.sv
// Victim way selection: lowest invalid way, else the round-robin pointer.
module wiredng_cache_victim_sel #(
    parameter int WAY_COUNT = 4,
    localparam int PTR_W = $clog2(WAY_COUNT)
) (
    input  logic [WAY_COUNT-1:0] way_valid_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [WAY_COUNT-1:0] victim_o,
    output logic                 all_valid_o
);

    logic found;

    always_comb begin
        victim_o    = '0;
        found       = 1'b0;
        all_valid_o = &way_valid_i;
        if (all_valid_o) begin
            victim_o[rr_ptr_i] = 1'b1;
        end else begin
            for (int i = 0; i < WAY_COUNT; i++) begin
                if (!way_valid_i[i] && !found) begin
                    victim_o[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wiredng_cache_refill.sv
// Miss-refill engine: picks a victim, fetches a 2-beat line and
// installs data and tag, then pulses done so the pipeline replays.
module wiredng_cache_refill
    import wiredng_cache_pkg::*;
#(
    parameter int WAY_COUNT = 4,
    parameter int PA_LENGTH = CACHE_PA_LENGTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        miss_valid_i,
    input  logic [PA_LENGTH-1:4]        miss_paddr_i,
    input  logic [WAY_COUNT-1:0]        way_valid_i,
    output logic                        busy_o,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [PA_LENGTH-1:4]        mem_req_addr_o,
    input  logic                        mem_rsp_valid_i,
    input  logic [63:0]                 mem_rsp_data_i,
    input  logic                        mem_rsp_err_i,
    output logic                        sram_we_o,
    output logic [9:0]                  sram_addr_o,
    output logic [WAY_COUNT-1:0]        sram_way_o,
    output logic                        sram_beat_o,
    output logic [63:0]                 sram_wdata_o,
    output logic                        tag_we_o,
    output cache_tag_t                  tag_wdata_o,
    output logic                        refill_done_o,
    output logic                        refill_err_o
);

    localparam int PTR_W  = $clog2(WAY_COUNT);
    localparam int BEAT_W = $clog2(BEATS_PER_LINE);

    refill_state_t            state_q, state_d;
    logic [PA_LENGTH-1:4]     addr_q, addr_d;
    logic [WAY_COUNT-1:0]     way_q, way_d;
    logic [PTR_W-1:0]         rr_q, rr_d;
    logic [BEAT_W-1:0]        cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     busy_q;
    logic                     rsp_v_q;
    logic                     rsp_err_q;
    logic [63:0]              rsp_data_q;
    logic [WAY_COUNT-1:0]     victim;
    logic                     all_valid;
    logic                     beat_take;

    wiredng_cache_victim_sel #(
        .WAY_COUNT(WAY_COUNT)
    ) u_victim_sel (
        .way_valid_i(way_valid_i),
        .rr_ptr_i   (rr_q),
        .victim_o   (victim),
        .all_valid_o(all_valid)
    );

    // Beats outside RECV are dropped, including stragglers after a reset.
    assign beat_take = mem_rsp_valid_i && (state_q == ST_RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            way_q      <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_v_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
            rsp_v_q <= beat_take;
            if (beat_take) begin
                rsp_err_q  <= mem_rsp_err_i;
                rsp_data_q <= mem_rsp_data_i;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        way_d           = way_q;
        rr_d            = rr_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        mem_req_valid_o = 1'b0;
        sram_we_o       = 1'b0;
        tag_we_o        = 1'b0;
        tag_wdata_o     = '0;
        refill_done_o   = 1'b0;
        refill_err_o    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid_i) begin
                    addr_d  = miss_paddr_i;
                    way_d   = victim;
                    state_d = ST_REQ;
                    if (all_valid) begin
                        rr_d = rr_q + 1'b1;
                    end
                end
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rsp_v_q) begin
                    sram_we_o = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    err_d     = err_q | rsp_err_q;
                    if (cnt_q == BEAT_W'(BEATS_PER_LINE - 1)) begin
                        state_d = ST_TAG;
                    end
                end
            end
            ST_TAG: begin
                tag_we_o          = 1'b1;
                tag_wdata_o.valid = !err_q;
                tag_wdata_o.tag   = addr_q[PA_LENGTH-1:TAG_LSB];
                state_d           = ST_DONE;
            end
            ST_DONE: begin
                refill_done_o = 1'b1;
                refill_err_o  = err_q;
                err_d         = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o         = busy_q;
    assign mem_req_addr_o = addr_q;
    assign sram_addr_o    = addr_q[INDEX_MSB:INDEX_LSB];
    assign sram_way_o     = way_q;
    assign sram_beat_o    = cnt_q;
    assign sram_wdata_o   = rsp_data_q;

    a_no_miss_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(miss_valid_i && busy_o));

    a_rsp_in_recv: assert property (
        @(posedge clk) disable iff (!rst_n)
        mem_rsp_valid_i |-> (state_q inside {ST_IDLE, ST_RECV}));

endmodule

// File: tb/tb_wiredng_cache_refill.sv
// Randomized bench for the refill engine against a transaction-level model.
module tb_wiredng_cache_refill;
    import wiredng_cache_pkg::*;

    localparam int W  = 4;
    localparam int PA = 48;
    localparam int LA = PA - 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_valid_i;
    logic [PA-1:4] miss_paddr_i;
    logic [W-1:0]  way_valid_i;
    logic          busy_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [PA-1:4] mem_req_addr_o;
    logic          mem_rsp_valid_i;
    logic [63:0]   mem_rsp_data_i;
    logic          mem_rsp_err_i;
    logic          sram_we_o;
    logic [9:0]    sram_addr_o;
    logic [W-1:0]  sram_way_o;
    logic          sram_beat_o;
    logic [63:0]   sram_wdata_o;
    logic          tag_we_o;
    cache_tag_t    tag_wdata_o;
    logic          refill_done_o;
    logic          refill_err_o;

    always #5 clk = ~clk;

    wiredng_cache_refill #(.WAY_COUNT(W), .PA_LENGTH(PA)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i),
        .way_valid_i(way_valid_i), .busy_o(busy_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
        .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_way_o(sram_way_o), .sram_beat_o(sram_beat_o),
        .sram_wdata_o(sram_wdata_o), .tag_we_o(tag_we_o),
        .tag_wdata_o(tag_wdata_o), .refill_done_o(refill_done_o),
        .refill_err_o(refill_err_o)
    );

    typedef struct {
        logic [9:0]   idx;
        logic [W-1:0] way;
        logic         beat;
        logic [63:0]  data;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_wr = 0;
    int          rr = 0;
    wr_t         exp_wr[$];
    cache_tag_t  exp_tag[$];
    logic        exp_done[$];
    logic [LA-1:0] cur_addr;
    logic [9:0]  cur_idx;
    logic [W-1:0] cur_way;
    cache_tag_t  last_tag;
    logic        last_err;
    logic [9:0]  last_idx;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event want none (t=%0t)", name, $time);
    endtask

    task automatic model_victim(input logic [W-1:0] vv, output logic [W-1:0] v);
        int pick;
        pick = -1;
        for (int i = W - 1; i >= 0; i--) if (!vv[i]) pick = i;
        if (pick < 0) begin
            pick = rr;
            rr = (rr + 1) % W;
        end
        v = W'(1) << pick;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sram_we_o) begin
                n_wr++;
                last_idx = sram_addr_o;
                if (exp_wr.size() == 0) miss_fail("unexpected_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_idx", 64'(sram_addr_o), 64'(e.idx));
                    chk("wr_way", 64'(sram_way_o), 64'(e.way));
                    chk("wr_beat", 64'(sram_beat_o), 64'(e.beat));
                    chk("wr_data", sram_wdata_o, e.data);
                end
            end
            if (tag_we_o) begin
                last_tag = tag_wdata_o;
                if (exp_tag.size() == 0) miss_fail("unexpected_tag");
                else chk("tag_wdata", 64'(tag_wdata_o), 64'(exp_tag.pop_front()));
            end
            if (refill_done_o) begin
                last_err = refill_err_o;
                if (exp_done.size() == 0) miss_fail("unexpected_done");
                else chk("done_err", 64'(refill_err_o), 64'(exp_done.pop_front()));
            end
            if (mem_req_valid_o)
                chk("req_addr", 64'(mem_req_addr_o), 64'(cur_addr));
            if (busy_o) begin
                chk("sram_idx", 64'(sram_addr_o), 64'(cur_idx));
                chk("sram_way", 64'(sram_way_o), 64'(cur_way));
            end
        end
    end

    task automatic start_miss(input logic [W-1:0] vv, input logic [LA-1:0] line,
                              input logic err, output logic [W-1:0] vic);
        cache_tag_t t;
        model_victim(vv, vic);
        cur_addr = line;
        cur_idx  = line[9:0];
        cur_way  = vic;
        t.valid  = !err;
        t.tag    = line[LA-1:10];
        exp_tag.push_back(t);
        exp_done.push_back(err);
        miss_valid_i = 1'b1;
        miss_paddr_i = line;
        way_valid_i  = vv;
    endtask

    task automatic send_beat(input logic b, input logic e, input logic [W-1:0] vic);
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        exp_wr.push_back('{cur_idx, vic, b, d});
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        mem_rsp_err_i   = e;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = {$urandom(), $urandom()};
        mem_rsp_err_i   = 1'b0;
    endtask

    task automatic refill(input logic [W-1:0] vv, input logic [LA-1:0] line,
                          input int rw, input int gap, input logic e0,
                          input logic e1, output logic [W-1:0] vic,
                          output int lat);
        int c0;
        int k;
        start_miss(vv, line, e0 | e1, vic);
        c0 = cyc;
        @(negedge clk);
        miss_valid_i = 1'b0;
        way_valid_i  = W'($urandom());
        chk("busy_rise", 64'(busy_o), 64'd1);
        repeat (rw) @(negedge clk);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        send_beat(1'b0, e0, vic);
        repeat (gap) @(negedge clk);
        send_beat(1'b1, e1, vic);
        k = 0;
        while (!refill_done_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!refill_done_o) begin
            miss_fail("done_timeout");
            lat = -1;
        end else begin
            lat = cyc - c0;
        end
        @(negedge clk);
        chk("busy_fall", 64'(busy_o), 64'd0);
    endtask

    logic [W-1:0] v;
    int lat;
    int rw, gap;
    logic e0, e1;
    logic [W-1:0] vv;
    logic [LA-1:0] line;
    int w0;

    initial begin
        rst_n = 1'b0;
        miss_valid_i = 1'b0;
        miss_paddr_i = '0;
        way_valid_i = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i = '0;
        mem_rsp_err_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_req", 64'(mem_req_valid_o), 64'd0);
        chk("rst_addr", 64'(mem_req_addr_o), 64'd0);
        chk("rst_we", 64'({sram_we_o, tag_we_o, refill_done_o, refill_err_o}), 64'd0);
        chk("rst_way", 64'(sram_way_o), 64'd0);
        chk("rst_tag", 64'(tag_wdata_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        refill(4'b0000, 44'h0123456789A, 0, 0, 1'b0, 1'b0, v, lat);
        chk("cold_victim", 64'(v), 64'h1);
        chk("cold_lat", 64'(lat), 64'd6);
        chk("cold_tag", 64'(last_tag), {29'd0, 1'b1, 34'h48D159E});
        chk("cold_idx", 64'(last_idx), 64'h09A);

        refill(4'b0111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b0, v, lat);
        chk("partial_victim", 64'(v), 64'h8);
        chk("partial_rr", 64'(rr), 64'd0);

        refill(4'b1111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b0, v, lat);
        chk("full0_victim", 64'(v), 64'h1);
        refill(4'b1111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b0, v, lat);
        chk("full1_victim", 64'(v), 64'h2);
        refill(4'b1111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b0, v, lat);
        chk("full2_victim", 64'(v), 64'h4);
        chk("full_rr", 64'(rr), 64'd3);

        refill(4'b0011, LA'({$urandom(), $urandom()}), 5, 3, 1'b0, 1'b0, v, lat);
        chk("bp_lat", 64'(lat), 64'd14);
        chk("bp_victim", 64'(v), 64'h4);

        refill(4'b1111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b1, v, lat);
        chk("err_flag", 64'(last_err), 64'd1);
        chk("err_tag_valid", 64'(last_tag.valid), 64'd0);
        chk("err_victim", 64'(v), 64'h8);
        refill(4'b1111, LA'({$urandom(), $urandom()}), 0, 0, 1'b0, 1'b0, v, lat);
        chk("after_err_flag", 64'(last_err), 64'd0);
        chk("rr_wrap_victim", 64'(v), 64'h1);

        start_miss(4'b1111, LA'({$urandom(), $urandom()}), 1'b0, v);
        @(negedge clk);
        miss_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        send_beat(1'b0, 1'b0, v);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_strobes",
            64'({mem_req_valid_o, sram_we_o, tag_we_o, refill_done_o}), 64'd0);
        chk("mid_rst_way", 64'(sram_way_o), 64'd0);
        chk("mid_rst_addr", 64'(mem_req_addr_o), 64'd0);
        exp_tag.delete();
        exp_done.delete();
        exp_wr.delete();
        rr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w0 = n_wr;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_no_write", 64'(n_wr), 64'(w0));
        chk("stray_busy", 64'(busy_o), 64'd0);
        refill(4'b1111, LA'({$urandom(), $urandom()}), 1, 1, 1'b0, 1'b0, v, lat);
        chk("post_rst_victim", 64'(v), 64'h1);
        chk("post_rst_lat", 64'(lat), 64'd8);

        for (int i = 0; i < 40; i++) begin
            vv = ($urandom_range(0, 2) == 0) ? 4'b1111 : W'($urandom());
            line = LA'({$urandom(), $urandom()});
            rw = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            e0 = ($urandom_range(0, 4) == 0);
            e1 = ($urandom_range(0, 4) == 0);
            refill(vv, line, rw, gap, e0, e1, v, lat);
            chk("rand_lat", 64'(lat), 64'(6 + rw + gap));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("left_wr", 64'(exp_wr.size()), 64'd0);
        chk("left_tag", 64'(exp_tag.size()), 64'd0);
        chk("left_done", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wiredng_cache_refill.md
Name: wiredng_cache_refill

Overview:
Miss-refill engine directly downstream of the cache bank hit stage. It consumes the stage-3 miss indication and the missing physical address, then selects a victim way. It fetches the 16-byte line as two 64-bit beats over a valid/ready memory port and writes the data and tag SRAMs, finishing with a done pulse so the pipeline replays the access. While a refill is in flight it holds the pipeline stalled via busy_o.

Parameters:
WAY_COUNT, 4, ways per set; power of two, 2..8.
PA_LENGTH, 48, physical address width in bits.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
miss_valid_i  in  1  stage-3 miss; sampled only in IDLE.
miss_paddr_i  in  PA_LENGTH-4  [PA_LENGTH-1:4] line address of the miss.
way_valid_i  in  WAY_COUNT  stage-3 per-way valid bits of the missing set.
busy_o  out  1  refill in progress; pipeline must hold.
mem_req_valid_o  out  1  line read request valid.
mem_req_ready_i  in  1  memory accepts the request.
mem_req_addr_o  out  PA_LENGTH-4  [PA_LENGTH-1:4] line address.
mem_rsp_valid_i  in  1  response beat valid; there is no backpressure.
mem_rsp_data_i  in  64  beat data; beat 0 = bytes 7:0.
mem_rsp_err_i  in  1  bus error on this beat.
sram_we_o  out  1  data SRAM write strobe.
sram_addr_o  out  10  [13:4] set index.
sram_way_o  out  WAY_COUNT  one-hot victim way.
sram_beat_o  out  1  address bit 3 (beat select).
sram_wdata_o  out  64  write data.
tag_we_o  out  1  tag SRAM write strobe (same addr/way).
tag_wdata_o  out  cache_tag_t  {valid, tag[PA_LENGTH-1:14]}.
refill_done_o  out  1  one-cycle pulse; refill finished.
refill_err_o  out  1  qualifies refill_done_o; line was not installed.

Behaviour:
- Reset: FSM = IDLE. All outputs = 0. Round-robin pointer = 0. Captured address = 0. Beat counter = 0. Error flag = 0.
- States: IDLE, REQ, RECV, TAG, DONE.
- IDLE:
  - On miss_valid_i, capture miss_paddr_i and select the victim.
  - Victim = lowest-index way with way_valid_i = 0. If all ways are valid, victim = round-robin pointer, and the pointer increments mod WAY_COUNT.
  - Go to REQ. busy_o is registered and goes high the next cycle.
- REQ: mem_req_valid_o = 1 and mem_req_addr_o = captured address, held stable until mem_req_ready_i. The request is accepted on the cycle valid&&ready; go to RECV and clear the beat counter.
- RECV:
  - Each mem_rsp_valid_i beat is registered.
  - The cycle after the beat: sram_we_o = 1, sram_beat_o = beat counter, sram_wdata_o = beat data.
  - The beat counter increments; mem_rsp_err_i ORs into the error flag.
  - After the second beat's write cycle, go to TAG.
  - Beats are written even when in error.
- TAG: tag_we_o = 1 for one cycle. tag_wdata_o = {!err, captured tag}, so an erroring refill invalidates the way. Go to DONE.
- DONE: refill_done_o = 1 and refill_err_o = error flag for one cycle. busy_o drops with the transition to IDLE (low in the next cycle). The error flag clears.
- Minimum latency, miss to done pulse, with ready and rsp immediate: 6 cycles.
- miss_valid_i outside IDLE is ignored (assertion: never asserted while busy_o).
- mem_rsp_valid_i outside RECV is ignored (assertion).
- sram_addr_o and sram_way_o stay constant from REQ through TAG.
- Asynchronous reset mid-refill: return immediately to IDLE with all strobes 0. Outstanding memory beats arriving afterwards are dropped in IDLE.
- Width: the tag is captured as [PA_LENGTH-1:14] and the index as [13:4]. The round-robin pointer is $clog2(WAY_COUNT) bits and wraps naturally.

Decomposition:
- Package wiredng_cache_pkg holds:
  - cache_tag_t: packed struct {logic valid; logic [PA_LENGTH-1:14] tag}, shared with the bank and tag SRAM.
  - constants LINE_BYTES=16, BEATS_PER_LINE=2, INDEX_LSB=4, INDEX_MSB=13.
  - the refill state enum.
- One sub-module: wiredng_cache_victim_sel. It is combinational: lowest-invalid priority encoder plus round-robin fallback, with the pointer register kept in the parent.

Test Plan:
- Cold miss: way_valid_i=4'b0000, paddr line 0x123456789A → victim way 0001, mem_req_addr_o=0x123456789A, two beats written with sram_beat_o 0 then 1. Tag write has valid=1 and tag=paddr[47:14]. refill_done_o pulses at cycle 6.
- Partial set: way_valid_i=4'b0111 → victim 1000. Round-robin pointer unchanged (0).
- Full set, three consecutive misses with way_valid_i=4'b1111 → victims 0001, 0010, 0100. Pointer ends at 3.
- Backpressure: hold mem_req_ready_i low for 5 cycles, then insert 3 idle cycles between beats → address stays stable, no SRAM writes in the gaps, refill_done_o at cycle 14.
- Error on beat 1 → both data writes occur, tag write has valid=0, and refill_done_o with refill_err_o=1. The next refill reports refill_err_o=0.
- Assert rst_n low during RECV after beat 0 → all outputs 0 next edge, FSM in IDLE. A stray mem_rsp_valid_i after reset produces no writes, and a new miss then completes normally.
